// File: rtl/sram1rw_rr_ctrl.sv
// Round-robin arbiter sharing one 1RW SRAM macro between NUM_REQ requesters, with optional zero-fill after reset.
// Latency: grant is combinational in the request cycle; read data and its strobe return one cycle after the grant.
// Backpressure: a requester waits while its ready is low; responses cannot be stalled and must be taken on the strobe.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset (outputs forced idle while low)
//   req_valid_i / req_ready_o  per-requester request handshake; transfer when both are high
//   req_we_i                   per-requester access type (1 = write, 0 = read)
//   req_addr_i / req_wdata_i   packed per-requester address / write data, requester i at slice i
//   rsp_valid_o / rsp_data_o   one-hot read-response strobe and the shared read-data bus
//   init_done_o                high once the zero-fill sweep has finished (at once if INIT_ZERO=0)
//   sram_*                     macro pins: A, WEB, CSB, OEB (all active low), I in, O out
module sram1rw_rr_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int INIT_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      init_done_o,
  output logic [ADDR_W-1:0]         sram_a_o,
  output logic                      sram_web_o,
  output logic                      sram_csb_o,
  output logic                      sram_oeb_o,
  output logic [DATA_W-1:0]         sram_i_o,
  input  logic [DATA_W-1:0]         sram_o_i
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  rsp_pend_q, rsp_pend_d;

  logic                gnt_vld;
  logic [RR_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                run_gnt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_ptr_q <= '0;
      rr_ptr_q   <= '0;
      rsp_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid index at or after rr_ptr_q, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_vld && req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = RR_W'(idx);
      end
    end
  end

  assign run_gnt = (state_q == ST_RUN) && gnt_vld;

  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_oh[k] = run_gnt && (gnt_idx == RR_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_pend_d = '0;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        // The last address is written in this cycle; service starts next cycle.
        if (&init_ptr_q) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (run_gnt) begin
          rr_ptr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          // The macro captures read data at this edge; the strobe follows next cycle.
          if (!req_we_i[gnt_idx]) begin
            rsp_pend_d = gnt_oh;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: everything idles while reset is held, independent of flop state.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    init_done_o = 1'b0;
    sram_a_o    = '0;
    sram_web_o  = 1'b1;
    sram_csb_o  = 1'b1;
    sram_oeb_o  = 1'b1;
    sram_i_o    = '0;
    if (rst_n) begin
      case (state_q)
        ST_INIT: begin
          sram_csb_o = 1'b0;
          sram_web_o = 1'b0;
          sram_a_o   = init_ptr_q;
        end
        default: begin
          init_done_o = 1'b1;
          req_ready_o = gnt_oh;
          if (gnt_vld) begin
            sram_csb_o = 1'b0;
            sram_web_o = ~req_we_i[gnt_idx];
            sram_a_o   = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
            sram_i_o   = req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
          end
        end
      endcase
      // Pending reads only ever arise in RUN, so this needs no state qualifier.
      if (|rsp_pend_q) begin
        rsp_valid_o = rsp_pend_q;
        sram_oeb_o  = 1'b0;
        rsp_data_o  = sram_o_i;
      end
    end
  end

endmodule

// File: tb/tb_sram1rw_rr_ctrl.sv
module tb_sram1rw_rr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: INIT_ZERO=1
  logic [1:0]  a_vld, a_rdy, a_we, a_rspv;
  logic [19:0] a_addr;
  logic [15:0] a_wdata;
  logic [7:0]  a_rspd, a_si, a_so;
  logic [9:0]  a_sa;
  logic        a_done, a_web, a_csb, a_oeb;

  // DUT Z: INIT_ZERO=0
  logic [1:0]  z_vld, z_rdy, z_we, z_rspv;
  logic [19:0] z_addr;
  logic [15:0] z_wdata;
  logic [7:0]  z_rspd, z_si, z_so;
  logic [9:0]  z_sa;
  logic        z_done, z_web, z_csb, z_oeb;

  sram1rw_rr_ctrl #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(8), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(a_vld), .req_ready_o(a_rdy), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata),
    .rsp_valid_o(a_rspv), .rsp_data_o(a_rspd), .init_done_o(a_done),
    .sram_a_o(a_sa), .sram_web_o(a_web), .sram_csb_o(a_csb), .sram_oeb_o(a_oeb),
    .sram_i_o(a_si), .sram_o_i(a_so)
  );

  sram1rw_rr_ctrl #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(8), .INIT_ZERO(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(z_vld), .req_ready_o(z_rdy), .req_we_i(z_we),
    .req_addr_i(z_addr), .req_wdata_i(z_wdata),
    .rsp_valid_o(z_rspv), .rsp_data_o(z_rspd), .init_done_o(z_done),
    .sram_a_o(z_sa), .sram_web_o(z_web), .sram_csb_o(z_csb), .sram_oeb_o(z_oeb),
    .sram_i_o(z_si), .sram_o_i(z_so)
  );

  // Behavioural 1RW macros: synchronous write, registered read data.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_z [1024];
  logic       seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int k = 0; k < 1024; k++) begin
        mem_a[k] <= 8'hA5;
        mem_z[k] <= 8'(k ^ 32'h3C);
      end
      seeded <= 1'b1;
    end else begin
      if (!a_csb) begin
        if (!a_web) mem_a[a_sa] <= a_si;
        else        a_so <= mem_a[a_sa];
      end
      if (!z_csb) begin
        if (!z_web) mem_z[z_sa] <= z_si;
        else        z_so <= mem_z[z_sa];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drv_a(input logic [1:0] v, input logic [1:0] we,
                       input logic [9:0] ad0, input logic [9:0] ad1,
                       input logic [7:0] d0, input logic [7:0] d1);
    a_vld   = v;
    a_we    = we;
    a_addr  = {ad1, ad0};
    a_wdata = {d1, d0};
  endtask

  task automatic drv_z(input logic [1:0] v, input logic [1:0] we,
                       input logic [9:0] ad0, input logic [9:0] ad1);
    z_vld   = v;
    z_we    = we;
    z_addr  = {ad1, ad0};
    z_wdata = 16'h0;
  endtask

  function automatic logic [7:0] zval(input int x);
    return 8'(x ^ 32'h3C);
  endfunction

  // Entered at negedge+1 of the first sweep cycle; leaves at negedge+1 of cycle n.
  task automatic sweep_a(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (a_csb !== 1'b0 || a_web !== 1'b0 || a_sa !== 10'(k) || a_si !== 8'h00 ||
          a_rdy !== 2'b00 || a_done !== 1'b0 || a_oeb !== 1'b1)
        bad++;
      @(negedge clk);
      #1;
    end
    chk(tag, bad, 0);
  endtask

  logic [1:0] t3_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] t3_r [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic [7:0] t3_d [4] = '{8'h00, 8'h11, 8'h22, 8'h11};

  initial begin
    drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    drv_z(2'b11, 2'b00, 10'h1, 10'h2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // Reset: everything idle, even with requests pending on Z.
    chk("rst_a_ready", a_rdy, 0);
    chk("rst_a_csb", a_csb, 1);
    chk("rst_a_web", a_web, 1);
    chk("rst_a_oeb", a_oeb, 1);
    chk("rst_a_addr", a_sa, 0);
    chk("rst_a_din", a_si, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_rspv", a_rspv, 0);
    chk("rst_z_ready", z_rdy, 0);
    chk("rst_z_csb", z_csb, 1);
    chk("rst_z_done", z_done, 0);

    // T1: release reset; Z serves at once, A sweeps 1024 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    drv_z(2'b00, 2'b00, 10'h0, 10'h0);
    #1;
    chk("t1_z_done", z_done, 1);
    chk("t1_z_csb_idle", z_csb, 1);
    sweep_a("t1_sweep", 1024);
    chk("t1_done", a_done, 1);
    chk("t1_idle_csb", a_csb, 1);

    @(negedge clk); drv_a(2'b01, 2'b00, 10'h3FF, 10'h0, 8'h0, 8'h0); #1;
    chk("t1_rd_ready", a_rdy, 2'b01);
    chk("t1_rd_csb", a_csb, 0);
    chk("t1_rd_web", a_web, 1);
    chk("t1_rd_addr", a_sa, 10'h3FF);
    @(negedge clk); drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0); #1;
    chk("t1_rsp_valid", a_rspv, 2'b01);
    chk("t1_rsp_data", a_rspd, 8'h00);
    chk("t1_rsp_oeb", a_oeb, 0);

    // T2: write then read-back of the same address in consecutive cycles.
    @(negedge clk); drv_a(2'b01, 2'b01, 10'h123, 10'h0, 8'h5A, 8'h0); #1;
    chk("t2_wr_ready", a_rdy, 2'b01);
    chk("t2_wr_web", a_web, 0);
    chk("t2_wr_din", a_si, 8'h5A);
    chk("t2_wr_addr", a_sa, 10'h123);
    @(negedge clk); drv_a(2'b01, 2'b00, 10'h123, 10'h0, 8'h0, 8'h0); #1;
    chk("t2_rd_ready", a_rdy, 2'b01);
    chk("t2_wr_no_rsp", a_rspv, 2'b00);
    chk("t2_rd_web", a_web, 1);
    @(negedge clk); drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0); #1;
    chk("t2_rsp_valid", a_rspv, 2'b01);
    chk("t2_rsp_data", a_rspd, 8'h5A);

    // T3 preload: req0 writes 0x11@0x010, req1 writes 0x22@0x020 (rr ptr ends at 0).
    @(negedge clk); drv_a(2'b01, 2'b01, 10'h010, 10'h0, 8'h11, 8'h0); #1;
    chk("t3_pre0_ready", a_rdy, 2'b01);
    @(negedge clk); drv_a(2'b10, 2'b10, 10'h0, 10'h020, 8'h0, 8'h22); #1;
    chk("t3_pre1_ready", a_rdy, 2'b10);
    chk("t3_pre1_addr", a_sa, 10'h020);
    chk("t3_pre1_din", a_si, 8'h22);

    // T3: both requesters read continuously.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drv_a(2'b11, 2'b00, 10'h010, 10'h020, 8'h0, 8'h0); #1;
      chk($sformatf("t3_grant%0d", c), a_rdy, t3_g[c]);
      chk($sformatf("t3_rspv%0d", c), a_rspv, t3_r[c]);
      chk($sformatf("t3_rspd%0d", c), a_rspd, t3_d[c]);
    end
    @(negedge clk); drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0); #1;
    chk("t3_rspv_last", a_rspv, 2'b10);
    chk("t3_rspd_last", a_rspd, 8'h22);

    // T6: idle in RUN keeps the rr ptr (set to 1 by a req0 grant first).
    @(negedge clk); drv_a(2'b01, 2'b00, 10'h010, 10'h0, 8'h0, 8'h0); #1;
    chk("t6_pre_ready", a_rdy, 2'b01);
    @(negedge clk); drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0); #1;
    chk("t6_pre_rspd", a_rspd, 8'h11);
    chk("t6_pre_csb", a_csb, 1);
    @(negedge clk); #1;
    chk("t6_csb", a_csb, 1);
    chk("t6_oeb", a_oeb, 1);
    chk("t6_ready", a_rdy, 0);
    chk("t6_rspv", a_rspv, 0);
    chk("t6_rspd", a_rspd, 0);
    @(negedge clk); #1;
    @(negedge clk); drv_a(2'b11, 2'b00, 10'h010, 10'h020, 8'h0, 8'h0); #1;
    chk("t6_ptr_held", a_rdy, 2'b10);
    @(negedge clk); drv_a(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0); #1;
    chk("t6_post_rspv", a_rspv, 2'b10);
    chk("t6_post_rspd", a_rspd, 8'h22);

    // T5: only req1 on Z, reading addresses 0..7 back to back.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); drv_z(2'b10, 2'b00, 10'h0, 10'(c)); #1;
      chk($sformatf("t5_ready%0d", c), z_rdy, 2'b10);
      chk($sformatf("t5_rspv%0d", c), z_rspv, (c == 0) ? 2'b00 : 2'b10);
      chk($sformatf("t5_rspd%0d", c), z_rspd, (c == 0) ? 8'h00 : zval(c - 1));
    end
    @(negedge clk); drv_z(2'b00, 2'b00, 10'h0, 10'h0); #1;
    chk("t5_rspv_last", z_rspv, 2'b10);
    chk("t5_rspd_last", z_rspd, zval(7));

    // Reset in the cycle after a read on Z discards the response.
    @(negedge clk); drv_z(2'b10, 2'b00, 10'h0, 10'h005); #1;
    chk("rr_read_ready", z_rdy, 2'b10);
    @(negedge clk); drv_z(2'b00, 2'b00, 10'h0, 10'h0); rst_n = 1'b0; #1;
    chk("rr_rspv_supp", z_rspv, 0);
    chk("rr_oeb_supp", z_oeb, 1);
    chk("rr_rspd_supp", z_rspd, 0);
    @(negedge clk); rst_n = 1'b1;
    drv_a(2'b11, 2'b00, 10'h010, 10'h020, 8'h0, 8'h0);
    #1;
    chk("rr_pend_dropped", z_rspv, 0);
    chk("rr_z_done", z_done, 1);

    // T4: A re-sweeps; reset at cycle 500 restarts the full sweep from 0.
    sweep_a("t4_sweep_part", 500);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_csb", a_csb, 1);
    chk("t4_rst_web", a_web, 1);
    chk("t4_rst_oeb", a_oeb, 1);
    chk("t4_rst_addr", a_sa, 0);
    chk("t4_rst_ready", a_rdy, 0);
    chk("t4_rst_done", a_done, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    sweep_a("t4_sweep_full", 1024);
    chk("t4_done", a_done, 1);
    chk("t4_first_grant", a_rdy, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
